// File: rtl/sram_host_pkg.sv
// Shared types and defaults for the serial-load SRAM host controller.
// The write-verify path is built only when SRAM_HOST_VERIFY_EN is defined.
package sram_host_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        GAP,
        WSTB,
        RSTB,
        WAIT,
        RESP
    } state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_TIMEOUT    = 15;

    // One counter width serves both the bit index and the wait timer
    function automatic int cnt_width(input int dw, input int to);
        int m;
        m = (dw > to + 1) ? dw : to + 1;
        return (m > 2) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/sram_host_ctrl_if.sv
// Request/response port plus the SRAM-side strobes of the host controller.
// master = environment/host view, slave = controller view.
interface sram_host_ctrl_if
    import sram_host_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  serial_in;
    logic                  shift;
    logic                  w_en;
    logic                  r_en;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output data_out, data_valid,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  serial_in, shift, w_en, r_en, addr
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  data_out, data_valid,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output serial_in, shift, w_en, r_en, addr
    );

endinterface

// File: rtl/sram_host_piso.sv
// Parallel-load, MSB-first shift register with a bit index counter.
module sram_host_piso #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = 4
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  advance,
    output logic                  bit_out,
    output logic                  last
);

    logic [DATA_WIDTH-1:0] sr_q;
    logic [CNT_W-1:0]      cnt_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (load) begin
            sr_q  <= data;
            cnt_q <= '0;
        end else if (advance) begin
            sr_q  <= sr_q << 1;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bit_out = sr_q[DATA_WIDTH-1];
    assign last    = (cnt_q == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/sram_host_ctrl.sv
// Host initiator for the serial-load SRAM: shifts writes in, strobes reads.
// Define SRAM_HOST_VERIFY_EN to read back and compare every write.
module sram_host_ctrl
    import sram_host_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             arst_n,
    sram_host_ctrl_if.slave  bus
);

    localparam int CW = cnt_width(DATA_WIDTH, TIMEOUT);

    state_t                state_q;
    logic                  ready_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  shift_q;
    logic                  w_en_q;
    logic                  r_en_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CW-1:0]         tcnt_q;
`ifdef SRAM_HOST_VERIFY_EN
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;
`endif

    logic accept;
    logic piso_bit;
    logic piso_last;

    assign accept = bus.req_valid & ready_q;

    sram_host_piso #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_W      (CW)
    ) u_piso (
        .clk     (clk),
        .arst_n  (arst_n),
        .load    (accept & bus.req_write),
        .data    (bus.req_wdata),
        .advance (state_q == SHIFT),
        .bit_out (piso_bit),
        .last    (piso_last)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= '0;
            shift_q     <= 1'b0;
            w_en_q      <= 1'b0;
            r_en_q      <= 1'b0;
            addr_q      <= '0;
            tcnt_q      <= '0;
`ifdef SRAM_HOST_VERIFY_EN
            write_q     <= 1'b0;
            wdata_q     <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        ready_q <= 1'b0;
                        addr_q  <= bus.req_addr;
`ifdef SRAM_HOST_VERIFY_EN
                        write_q <= bus.req_write;
                        wdata_q <= bus.req_wdata;
`endif
                        if (bus.req_write) begin
                            state_q <= SHIFT;
                            shift_q <= 1'b1;
                        end else begin
                            state_q <= RSTB;
                            r_en_q  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (piso_last) begin
                        shift_q <= 1'b0;
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    w_en_q  <= 1'b1;
                    state_q <= WSTB;
                end
                WSTB: begin
                    w_en_q <= 1'b0;
`ifdef SRAM_HOST_VERIFY_EN
                    r_en_q  <= 1'b1;
                    state_q <= RSTB;
`else
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rdata_q     <= '0;
                    state_q     <= RESP;
`endif
                end
                RSTB: begin
                    r_en_q  <= 1'b0;
                    tcnt_q  <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // Data arriving in the expiry cycle still counts
                    if (bus.data_valid) begin
                        rsp_valid_q <= 1'b1;
                        rdata_q     <= bus.data_out;
`ifdef SRAM_HOST_VERIFY_EN
                        rsp_err_q   <= write_q &&
                                       (bus.data_out != wdata_q);
`else
                        rsp_err_q   <= 1'b0;
`endif
                        state_q     <= RESP;
                    end else if (tcnt_q == CW'(TIMEOUT - 1)) begin
                        rsp_valid_q <= 1'b1;
                        rdata_q     <= '0;
                        rsp_err_q   <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        tcnt_q <= tcnt_q + CW'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        ready_q     <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.serial_in = piso_bit;
    assign bus.shift     = shift_q;
    assign bus.w_en      = w_en_q;
    assign bus.r_en      = r_en_q;
    assign bus.addr      = addr_q;

endmodule

// File: tb/tb_sram_host_ctrl.sv
// Directed + random bench for sram_host_ctrl with a behavioural SRAM model.
// Expectations track SRAM_HOST_VERIFY_EN when it is defined.
module tb_sram_host_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int TO = 15;
`ifdef SRAM_HOST_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic clk = 1'b0;
    logic arst_n = 1'b0;

    sram_host_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sram_host_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .TIMEOUT    (TO)
    ) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail = 0;
    logic [DW-1:0] mem [16];
    logic [DW-1:0] gold [16];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One request from presentation to response handshake.
    // d: cycles from r_en to the data_valid pulse (0 = never).
    task automatic txn(input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input int d,
                       input int hold, input bit hold_valid,
                       input bit ov_en, input logic [DW-1:0] ov);
        int rc, exp_lat, n, nshift, nw, nr, rcyc;
        bit tmo, done, exp_err;
        logic [DW-1:0] val, exp_rd, sh;
        rc = wr ? DW + 3 : 1;
        if (wr && !VERIFY) begin
            exp_lat = DW + 3;
            exp_rd = '0;
            exp_err = 1'b0;
        end else begin
            tmo = (d < 1) || (d > TO);
            exp_lat = tmo ? rc + 1 + TO : rc + d + 1;
            val = ov_en ? ov : (wr ? wd : gold[a]);
            exp_rd = tmo ? '0 : val;
            exp_err = tmo || (wr && val != wd);
        end
        if (wr) gold[a] = wd;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr = a;
        bus.req_wdata = wd;
        bus.data_valid = 1'b0;
        chk("ready_idle", bus.req_ready, 1);
        @(posedge clk);
        n = 0; nshift = 0; nw = 0; nr = 0; rcyc = -1;
        done = 0; sh = '0;
        while (!done) begin
            @(negedge clk);
            n++;
            if (!hold_valid) bus.req_valid = 1'b0;
            bus.req_addr = AW'($urandom);
            bus.req_wdata = DW'($urandom);
            bus.data_valid = 1'b0;
            bus.data_out = DW'($urandom);
            chk("strobe_excl",
                32'($onehot0({bus.shift, bus.w_en, bus.r_en})), 1);
            if (bus.shift) begin
                sh = {sh[DW-2:0], bus.serial_in};
                nshift++;
            end
            if (bus.w_en) begin
                nw++;
                mem[bus.addr] = sh;
                chk("w_en_addr", bus.addr, a);
                chk("w_en_cycle", n, DW + 2);
            end
            if (bus.r_en) begin
                nr++;
                rcyc = n;
                chk("r_en_addr", bus.addr, a);
                chk("r_en_cycle", n, rc);
            end
            if (rcyc > 0 && d > 0 && n == rcyc + d) begin
                bus.data_valid = 1'b1;
                bus.data_out = ov_en ? ov : mem[bus.addr];
            end
            if (bus.rsp_valid) begin
                chk("latency", n, exp_lat);
                chk("rsp_rdata", bus.rsp_rdata, exp_rd);
                chk("rsp_err", bus.rsp_err, exp_err);
                chk("busy_ready", bus.req_ready, 0);
                chk("nshift", nshift, wr ? DW : 0);
                if (wr) chk("serial_bits", sh, wd);
                chk("n_w_en", nw, wr ? 1 : 0);
                chk("n_r_en", nr, (!wr || VERIFY) ? 1 : 0);
                for (int h = 0; h < hold; h++) begin
                    bus.rsp_ready = 1'b0;
                    @(negedge clk);
                    bus.data_valid = 1'b0;
                    chk("rsp_hold",
                        {bus.rsp_valid, bus.rsp_err, bus.req_ready,
                         bus.rsp_rdata},
                        {1'b1, exp_err, 1'b0, exp_rd});
                end
                bus.rsp_ready = 1'b1;
                @(posedge clk);
                #1;
                bus.rsp_ready = 1'b0;
                done = 1;
            end else if (n > 80) begin
                chk("rsp_timeout", n, exp_lat);
                done = 1;
            end
        end
    endtask

    initial begin
        logic [DW-1:0] wd;
        bit bad;
        for (int i = 0; i < 16; i++) begin
            mem[i] = '0;
            gold[i] = '0;
        end
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus.data_out = '0;
        bus.data_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state",
            {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.serial_in,
             bus.shift, bus.w_en, bus.r_en, bus.rsp_rdata, bus.addr},
            {1'b1, 6'b0, 8'h00, 4'h0});
        arst_n = 1'b1;

        txn(1, 4'd3, 8'hA5, 1, 0, 0, 0, 8'h00);
        txn(0, 4'd3, 8'h00, 1, 0, 0, 0, 8'h00);
        txn(0, 4'd3, 8'h00, 2, 0, 0, 1, 8'h3C);
        txn(0, 4'd3, 8'h00, 0, 0, 0, 0, 8'h00);
        txn(0, 4'd3, 8'h00, TO, 0, 0, 0, 8'h00);
        txn(0, 4'd3, 8'h00, TO + 1, 0, 0, 0, 8'h00);
        txn(1, 4'd9, 8'h0F, 3, 5, 1, 0, 8'h00);
        txn(0, 4'd9, 8'h00, 4, 0, 0, 0, 8'h00);

        for (int i = 0; i < 16; i++) begin
            txn(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
                int'($urandom_range(0, TO + 2)),
                int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 0, 8'h00);
        end

        // Abort a write during its 4th shift cycle
        wd = DW'($urandom);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr = 4'd7;
        bus.req_wdata = wd;
        chk("abort_ready", bus.req_ready, 1);
        @(posedge clk);
        repeat (4) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
        end
        chk("abort_shift_on", bus.shift, 1);
        arst_n = 1'b0;
        #1;
        chk("abort_reset",
            {bus.shift, bus.w_en, bus.r_en, bus.rsp_valid, bus.req_ready},
            5'b00001);
        @(negedge clk);
        arst_n = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.w_en || bus.rsp_valid || !bus.req_ready) bad = 1;
        end
        chk("abort_quiet", bad, 0);

        txn(0, 4'd3, 8'h00, 1, 0, 0, 0, 8'h00);
        txn(1, 4'd5, 8'h5A, 1, 0, 0, 1, 8'h5B);
        txn(1, 4'd6, 8'hC3, 2, 1, 0, 0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_host_ctrl.md
Name: sram_host_ctrl

Overview:
- Host-side initiator for the serial-load SRAM macro (sram_top).
- Accepts parallel read/write requests on a valid/ready port.
- For writes: serializes the word MSB-first on serial_in/shift, then pulses w_en.
- For reads: pulses r_en, waits for data_valid, captures data_out and returns it on a response port.

Parameters:
- DATA_WIDTH, 8, word width; equals SRAM COLS.
- ADDR_WIDTH, 4, address width; matches SRAM addr.
- TIMEOUT, 15, max cycles to wait for data_valid after r_en; must be >= 1.

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller idle, accepts request
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_WIDTH  target address
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  response available; held until rsp_ready
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
- rsp_err  out  1  read timeout (or verify mismatch, see Optional Feature)
- serial_in  out  1  serial bit to SRAM
- shift  out  1  SRAM shift strobe
- w_en  out  1  SRAM write strobe
- r_en  out  1  SRAM read strobe
- addr  out  ADDR_WIDTH  SRAM address
- data_out  in  DATA_WIDTH  SRAM read data
- data_valid  in  1  SRAM read data valid

Behaviour:
- Reset (async, immediate): state IDLE; req_ready=1; rsp_valid=0, rsp_err=0, rsp_rdata=0; serial_in=0, shift=0, w_en=0, r_en=0, addr=0; bit counter=0, timeout counter=0.
- Reset mid-operation aborts the transaction. The partially shifted SRAM word is not recovered and no response is produced.
- Handshakes:
  - A request is accepted on the clk edge with req_valid & req_ready.
  - req_ready=1 only in IDLE.
  - A response completes on rsp_valid & rsp_ready; the controller then returns to IDLE.
- Registered capture: req_addr, req_wdata and req_write are captured on accept. addr drives the captured address and is held from the cycle after accept until the return to IDLE.
- FSM states: IDLE, SHIFT, GAP, WSTB, RSTB, WAIT, RESP.
  - IDLE -> SHIFT (write) or RSTB (read) on accept.
  - SHIFT, DATA_WIDTH cycles:
    - shift=1; serial_in = wdata[DATA_WIDTH-1-k] in cycle k (MSB first).
    - Bit counter runs 0..DATA_WIDTH-1; at the last bit go to GAP.
  - GAP, 1 cycle: shift=0, all strobes 0. Lets the SRAM shift register settle. Then WSTB.
  - WSTB, 1 cycle: w_en=1. Then RESP with rsp_err=0, rsp_rdata=0.
  - RSTB, 1 cycle: r_en=1. Then WAIT.
  - WAIT:
    - data_valid is sampled each cycle.
    - On data_valid=1: rsp_rdata <= data_out, rsp_err=0, go to RESP.
    - Timeout counter increments each WAIT cycle. When it reaches TIMEOUT without data_valid: rsp_err=1, rsp_rdata=0, go to RESP.
    - If data_valid and expiry coincide, data wins.
  - RESP: rsp_valid=1, held together with rsp_rdata and rsp_err until rsp_ready. Then IDLE.
- Strobe exclusivity: shift, w_en and r_en are registered and mutually exclusive. At most one is high in any cycle.
- Ignored inputs:
  - data_valid outside WAIT.
  - req_valid while not IDLE.
- Minimum latencies, accept to rsp_valid:
  - Write: DATA_WIDTH+3 cycles.
  - Read: 3 cycles when data_valid is high in the first WAIT cycle.
- Back-to-back: the next request can be accepted in the cycle after the rsp handshake.

Optional Feature:
- Macro: SRAM_HOST_VERIFY_EN.
- Defined:
  - After WSTB, the write path continues through RSTB and WAIT instead of going straight to RESP.
  - The read-back value is compared with the captured wdata.
  - rsp_err=1 on mismatch or timeout; rsp_rdata carries the read-back value.
  - Write latency grows by the read time.
- Undefined: write ends at WSTB -> RESP as specified in Behaviour.

Decomposition:
- sram_host_pkg:
  - state_t enum: IDLE, SHIFT, GAP, WSTB, RSTB, WAIT, RESP.
  - Default width/timeout localparams.
  - Function computing the counter width, clog2 of max(DATA_WIDTH, TIMEOUT+1).
- Sub-module sram_host_piso:
  - Parallel-load, MSB-first shift register plus bit counter.
  - Ports: load, data, advance, bit_out, last.
  - Instantiated once; the FSM drives load and advance.

Test Plan:
1. Write addr=3, wdata=0xA5 -> serial_in sequence 1,0,1,0,0,1,0,1 with shift=1 for 8 cycles; GAP cycle; w_en=1 for one cycle; rsp_valid 11 cycles after accept, rsp_err=0. Against sram_top, a read of addr 3 returns 0xA5.
2. Read addr=3, SRAM model raises data_valid with data_out=0x3C two cycles after r_en -> rsp_rdata=0x3C, rsp_err=0; exactly one r_en pulse.
3. Read with data_valid never asserted -> rsp_valid after TIMEOUT=15 WAIT cycles, rsp_err=1, rsp_rdata=0x00.
4. Hold rsp_ready=0 for 5 cycles after rsp_valid; assert req_valid throughout -> response stable, req_ready=0; new request accepted the cycle after rsp_ready=1.
5. Assert arst_n=0 on the 4th SHIFT cycle -> shift, w_en, r_en and rsp_valid drop immediately, req_ready=1; no w_en is ever issued for the aborted write.
6. With SRAM_HOST_VERIFY_EN, write 0x5A while the model returns 0x5B -> rsp_err=1, rsp_rdata=0x5B.
